// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX bit-timing controller for an external 10-bit shift register.
// Optional macro UART_RX_SYNC_EN: 2-flop synchronizer on rx_in (adds 2 cycles of latency).
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [9:0] frame,
  output logic       shift_en,
  output logic       shift_bit,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      r_bit_cnt;
  logic [2:0]      w_bit_cnt_nxt;
  logic            w_rxs;
  logic            w_shift;
  logic            w_done;
  logic            w_load;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_in};
    end
  end

  assign w_rxs = r_sync[1];
`else
  assign w_rxs = rx_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) w_state_nxt = S_START;
      end
      // Start bit is re-checked at mid-bit; a high line here is treated as a glitch.
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          if (!w_rxs) begin
            w_shift       = 1'b1;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_shift       = 1'b1;
          w_cnt_nxt     = '0;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_shift     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign shift_en  = w_shift & rst;
  assign shift_bit = w_rxs;

  // A consume in the DONE cycle frees the slot, so the new byte lands without overrun.
  assign w_done = (r_state == S_DONE);
  assign w_load = w_done & (~rx_valid | rx_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        rx_data   <= frame[8:1];
        frame_err <= frame[0] | ~frame[9];
        rx_valid  <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (w_done && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
